// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serial memory controller: width codes,
// FSM states and byte-lane helpers.
package mem_ctrl_pkg;

  localparam logic        RST_ENABLE = 1'b1;
  localparam logic [31:0] ZERO_WORD  = '0;

  localparam logic [1:0] W_BYTE = 2'b00;
  localparam logic [1:0] W_HALF = 2'b01;
  localparam logic [1:0] W_WORD = 2'b10;

  typedef enum logic [1:0] {IDLE, IF_RD, MEM_RD, MEM_WR} state_t;

  // Width code 11 is treated as a full word.
  function automatic logic [2:0] width_bytes(input logic [1:0] w);
    case (w)
      W_BYTE:         return 3'd1;
      W_HALF:         return 3'd2;
      W_WORD, 2'b11:  return 3'd4;
      default:        return 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] lane,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = w;
    r[{lane, 3'b000} +: 8] = b;
    return r;
  endfunction

  function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] lane);
    return w[{lane, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// CPU-side request/response signals and the shared 8-bit RAM port.
interface mem_ctrl_if #(parameter int unsigned ADDR_W = 32) ();
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic              if_done;
  logic [31:0]       if_inst;
  logic              mem_req;
  logic              mem_wr;
  logic [1:0]        mem_width;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_done;
  logic [31:0]       mem_rdata;
  logic [ADDR_W-1:0] ram_a;
  logic              ram_wr;
  logic [7:0]        ram_dout;
  logic [7:0]        ram_din;

  modport slave (
    input  if_req, if_addr, if_flush, mem_req, mem_wr, mem_width, mem_addr, mem_wdata, ram_din,
    output if_done, if_inst, mem_done, mem_rdata, ram_a, ram_wr, ram_dout
  );

  modport master (
    output if_req, if_addr, if_flush, mem_req, mem_wr, mem_width, mem_addr, mem_wdata, ram_din,
    input  if_done, if_inst, mem_done, mem_rdata, ram_a, ram_wr, ram_dout
  );
endinterface

// File: rtl/mem_ctrl.sv
// Arbitrates the single byte-wide RAM port between instruction fetch and
// MEM-stage loads/stores, sequencing 1/2/4-byte little-endian transfers.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic      clk,
  input  logic      rst,
  mem_ctrl_if.slave bus
);

  state_t            state, state_nx;
  logic [2:0]        c, n;
  logic [ADDR_W-1:0] base;
  logic [31:0]       wdata, asm_q, asm_nx;
  logic              done_any, flush_hit;

  assign done_any  = bus.if_done | bus.mem_done;
  assign flush_hit = (state == IF_RD) && bus.if_flush;
  // RAM data arriving in cycle c belongs to the address driven in cycle c-1.
  assign asm_nx    = put_byte(asm_q, 2'(c - 3'd1), bus.ram_din);

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) state <= IDLE;
    else                   state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (!done_any) begin
          if (bus.mem_req)                       state_nx = bus.mem_wr ? MEM_WR : MEM_RD;
          else if (bus.if_req && !bus.if_flush)  state_nx = IF_RD;
        end
      end
      IF_RD:   if (bus.if_flush || c == n) state_nx = IDLE;
      MEM_RD:  if (c == n)                 state_nx = IDLE;
      MEM_WR:  if (c == n - 3'd1)          state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.ram_a    = '0;
    bus.ram_wr   = 1'b0;
    bus.ram_dout = '0;
    unique case (state)
      IF_RD, MEM_RD: if (c < n) bus.ram_a = base + ADDR_W'(c);
      MEM_WR: begin
        bus.ram_a    = base + ADDR_W'(c);
        bus.ram_wr   = 1'b1;
        bus.ram_dout = get_byte(wdata, c[1:0]);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      c             <= '0;
      n             <= '0;
      base          <= '0;
      wdata         <= ZERO_WORD;
      asm_q         <= ZERO_WORD;
      bus.if_done   <= 1'b0;
      bus.mem_done  <= 1'b0;
      bus.if_inst   <= ZERO_WORD;
      bus.mem_rdata <= ZERO_WORD;
    end else begin
      bus.if_done  <= 1'b0;
      bus.mem_done <= 1'b0;
      unique case (state)
        IDLE: begin
          c     <= '0;
          asm_q <= ZERO_WORD;
          if (state_nx == IF_RD) begin
            base <= bus.if_addr;
            n    <= 3'd4;
          end else if (state_nx != IDLE) begin
            base  <= bus.mem_addr;
            n     <= width_bytes(bus.mem_width);
            wdata <= bus.mem_wdata;
          end
        end
        IF_RD, MEM_RD: begin
          c <= c + 3'd1;
          if (c != '0) asm_q <= asm_nx;
          // A flush on the completing edge still suppresses the fetch result.
          if (c == n && !flush_hit) begin
            if (state == IF_RD) begin
              bus.if_inst <= asm_nx;
              bus.if_done <= 1'b1;
            end else begin
              bus.mem_rdata <= asm_nx;
              bus.mem_done  <= 1'b1;
            end
          end
        end
        MEM_WR: begin
          c <= c + 3'd1;
          if (c == n - 3'd1) bus.mem_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Byte-serial memory controller that shares the CPU's single 8-bit RAM port between instruction fetch (IF) and the MEM stage's loads/stores. MEM-stage transactions come from EX status `011` (load) and `010` (store). The block arbitrates between the two requesters, sequences 1/2/4 byte transfers, and returns assembled little-endian data with a one-cycle done pulse. Pipeline stalls are derived from req-high/done-low.

## Interface
Parameters:
- `ADDR_W`, 32, address width of all address ports.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `if_req`  in  1  fetch request, held high until `if_done` or flush.
- `if_addr`  in  ADDR_W  fetch address; always a 4-byte read.
- `if_flush`  in  1  branch/jump taken; aborts any fetch in progress.
- `if_done`  out  1  one-cycle pulse; `if_inst` is valid.
- `if_inst`  out  32  fetched word.
- `mem_req`  in  1  data request, held until `mem_done`.
- `mem_wr`  in  1  1 = store, 0 = load.
- `mem_width`  in  2  00 = byte, 01 = half, 10 = word; 11 is treated as word.
- `mem_addr`  in  ADDR_W  byte address.
- `mem_wdata`  in  32  store data; low bytes used.
- `mem_done`  out  1  one-cycle pulse on completion of a load or store.
- `mem_rdata`  out  32  load data, zero-extended; the MEM stage performs sign extension.
- `ram_a`  out  ADDR_W  RAM byte address.
- `ram_wr`  out  1  RAM write strobe.
- `ram_dout`  out  8  RAM write data.
- `ram_din`  in  8  RAM read data, valid the cycle after its address is driven.

## Operation
FSM states: IDLE, IF_RD, MEM_RD, MEM_WR. A byte counter `c` (0..4) and a 32-bit assembly register support the sequencing.

**IDLE**
- Drives `ram_a`=0, `ram_wr`=0, `ram_dout`=0.
- Accepts a request at the clock edge only if neither done output is high in that cycle. This guarantees a one-cycle bubble that lets the requester drop `req`.

**Arbitration**
- `mem_req` has priority over `if_req`, because MEM holds the older instruction.
- An IF request with `if_flush` high in the same cycle is not accepted.
- On acceptance, latch the address, width (n = 1/2/4), write data and direction, and set `c`=0.

**MEM_RD / IF_RD, for state cycle c = 0..n**
- While c<n: drive `ram_a`=base+c and `ram_wr`=0.
- While c≥1: capture `ram_din` into byte lane c−1 of the assembly register.
- At the edge ending c=n: register the assembled data to `mem_rdata`/`if_inst`, pulse the done output, and return to IDLE.

**MEM_WR, for c = 0..n−1**
- Drive `ram_a`=base+c, `ram_wr`=1, `ram_dout`=`mem_wdata`[8c+7:8c].
- At the edge ending c=n−1: pulse `mem_done` and return to IDLE.

**Arithmetic**
- Address increment is modulo 2^ADDR_W; 0xFFFFFFFF+1 wraps to 0.
- Byte lanes are little-endian.
- Bytes not read are 0.

**Flush**
- `if_flush` high during IF_RD: go to IDLE at the next edge, suppress `if_done`, and discard captured bytes. This applies even if that edge would have completed the fetch.
- Flush has no effect on MEM_RD or MEM_WR.

**Reset**
- With `rst` high at an edge: state IDLE, `c`=0, all outputs 0.
- A transaction in progress is abandoned with no done pulse.

## Timing
- Reset value of every output is 0.
- Load latency, counting from the accepting edge to the done-high cycle, is n+1 cycles: LB 2, LH 3, LW 5.
- IF fetch latency is 5 cycles.
- Store latency is n cycles: SB 1, SH 2, SW 4.
- Done outputs are registered, high for exactly one cycle. `mem_rdata`/`if_inst` hold their value until the next completion.
- Minimum request-to-request spacing is latency+1 (the done bubble).
- `if_done` and `mem_done` are never high in the same cycle.

## Structure
- Shared defines (Defines.v): width codes `W_BYTE`/`W_HALF`/`W_WORD`, FSM state encodings, and the existing `rst_enable` and `zeroword`.
- A single module; no sub-module is natural.

## Test plan
- **LW**: RAM[0x100..0x103]=0x11,0x22,0x33,0x44; `mem_req`, width 10, addr 0x100 → `ram_a` 0x100..0x103 on consecutive cycles, then `mem_done` 5 cycles after acceptance with `mem_rdata`=0x44332211.
- **SH then LBU**: SH with `mem_wdata`=0xDEADBEEF at 0x200 → `ram_wr` for 2 cycles with bytes 0xEF then 0xBE, `mem_done` at cycle 2. A following LB at 0x201 → `mem_rdata`=0x000000BE.
- **Arbitration**: `if_req` and `mem_req` both high in IDLE → MEM served first. IF is accepted only after the `mem_done` bubble, and `if_done` arrives 5 cycles later.
- **Flush**:
  - `if_flush` in state cycle 2 of a fetch → IDLE next cycle, no `if_done`.
  - `if_flush` on the final cycle of a fetch → `if_done` suppressed.
- **Wrap**: LW at 0xFFFFFFFE → `ram_a` sequence FFFFFFFE, FFFFFFFF, 0, 1.
- **Reset mid-SW**: `rst` at store cycle 2 → `ram_wr`=0 next cycle, no `mem_done`, all outputs 0.
